// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access controller.
//   mem_size_t   : access width as seen on mem_size_m (11 folds onto WORD)
//   dmem_state_t : controller FSM states
//   WORD_BYTES   : bytes per bus word (width of bus_be)
//   decode_size  : maps the raw 2-bit size field onto mem_size_t
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    // The reserved encoding 11 behaves exactly like a word access.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        mem_size_t s;
        case (raw)
            2'b00:   s = BYTE;
            2'b01:   s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// Load data alignment: picks the addressed lane out of a bus word and
// sign- or zero-extends it to 32 bits.
//   word        in  32  captured bus word
//   offset      in  2   byte offset of the access within the word
//   size        in      access width
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        // Halves are only ever issued aligned, so offset[1] picks the lane.
        half_lane = offset[1] ? word[31:16] : word[15:0];
        fill      = 1'b0;
        case (size)
            BYTE: begin
                fill   = ~is_unsigned & byte_lane[7];
                result = {{24{fill}}, byte_lane};
            end
            HALF: begin
                fill   = ~is_unsigned & half_lane[15];
                result = {{16{fill}}, half_lane};
            end
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller behind the pipeline M stage.
// Accepts one load/store per instruction, runs it over a request/ack bus,
// stalls the pipeline while the bus is busy and returns extended load data.
//   clk, rst               clock; asynchronous active-high reset
//   mem_read_m/_write_m    load / store request (store wins if both)
//   mem_size_m             00 byte, 01 half, 10/11 word
//   mem_unsigned_m         zero-extend loads when set
//   alu_result_m           byte address
//   mem_write_data_m       right-justified store data
//   mem_read_data_m        extended load result, non-zero only in DONE
//   stall_m                freeze fetch through M
//   misalign_m             current request is misaligned (combinational)
//   timeout_m              sticky bus-timeout flag
//   bus_req/we/addr/be/wdata, bus_ack, bus_rdata : memory bus
//   state                  current FSM state, for observation
//
// Bus handshake: bus_req is high for every cycle spent in REQ and the
// request fields (we/addr/be/wdata) are constant while it is high; the
// transfer completes in the first REQ cycle that sees bus_ack high, and
// bus_rdata is only looked at in that cycle. bus_ack is ignored outside REQ.
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_m,
    input  logic                  mem_write_m,
    input  logic [1:0]            mem_size_m,
    input  logic                  mem_unsigned_m,
    input  logic [31:0]           alu_result_m,
    input  logic [31:0]           mem_write_data_m,
    output logic [31:0]           mem_read_data_m,
    output logic                  stall_m,
    output logic                  misalign_m,
    output logic                  timeout_m,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [WORD_BYTES-1:0] bus_be,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata,
    output dmem_state_t           state
);

    dmem_state_t           state_q, state_d;
    mem_size_t             req_size, size_q;
    logic                  pending, aligned;
    logic [WORD_BYTES-1:0] lane_be;
    logic [31:0]           lane_wdata;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [31:0]           rdata_q;
    logic [7:0]            wait_q, wait_inc;
    logic                  timeout_q;
    logic                  issue, ack_take, wait_expired;
    logic [31:0]           ext_data;

    assign state = state_q;

    // Request decode, only meaningful while in IDLE.
    assign pending  = mem_read_m | mem_write_m;
    assign req_size = decode_size(mem_size_m);

    always_comb begin
        aligned    = 1'b1;
        lane_be    = '1;
        lane_wdata = mem_write_data_m;
        case (req_size)
            BYTE: begin
                aligned    = 1'b1;
                lane_be    = 4'b0001 << alu_result_m[1:0];
                lane_wdata = {4{mem_write_data_m[7:0]}};
            end
            HALF: begin
                aligned    = ~alu_result_m[0];
                lane_be    = alu_result_m[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{mem_write_data_m[15:0]}};
            end
            default: begin
                aligned    = (alu_result_m[1:0] == 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = mem_write_data_m;
            end
        endcase
    end

    // wait_q counts completed REQ cycles; wait_inc is the count including
    // the current one, so expiry happens on the MAX_WAIT-th REQ cycle.
    assign wait_inc = wait_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stall_m      = 1'b0;
        misalign_m   = 1'b0;
        issue        = 1'b0;
        ack_take     = 1'b0;
        wait_expired = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    if (aligned) begin
                        stall_m = 1'b1;
                        issue   = 1'b1;
                        state_d = REQ;
                    end else begin
                        misalign_m = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_m = 1'b1;
                if (bus_ack) begin
                    ack_take = 1'b1;
                    state_d  = DONE;
                end else if (wait_inc == 8'(MAX_WAIT)) begin
                    wait_expired = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields and captured load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            size_q    <= BYTE;
            uns_q     <= 1'b0;
            off_q     <= '0;
            rdata_q   <= '0;
        end else begin
            if (issue) begin
                bus_we    <= mem_write_m;
                bus_addr  <= {alu_result_m[31:2], 2'b00};
                bus_be    <= lane_be;
                bus_wdata <= lane_wdata;
                size_q    <= req_size;
                uns_q     <= mem_unsigned_m;
                off_q     <= alu_result_m[1:0];
                // Cleared here so stores and timeouts return zero.
                rdata_q   <= '0;
            end else if (ack_take && !bus_we) begin
                rdata_q <= bus_rdata;
            end else if (wait_expired) begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q <= (state_q == REQ && state_d == REQ) ? wait_inc : 8'd0;
            if (wait_expired) timeout_q <= 1'b1;
        end
    end

    assign timeout_m = timeout_q;
    assign bus_req   = (state_q == REQ);

    load_extend u_load_extend (
        .word        (rdata_q),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    assign mem_read_data_m = (state_q == DONE) ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import mem_pkg::*;

  localparam int MW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_read_m, mem_write_m, mem_unsigned_m;
  logic [1:0]  mem_size_m;
  logic [31:0] alu_result_m, mem_write_data_m, mem_read_data_m;
  logic        stall_m, misalign_m, timeout_m;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  dmem_state_t state;

  dmem_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
    .alu_result_m(alu_result_m), .mem_write_data_m(mem_write_data_m),
    .mem_read_data_m(mem_read_data_m), .stall_m(stall_m),
    .misalign_m(misalign_m), .timeout_m(timeout_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .state(state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  bit model_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;      // REQ cycles without ack before the ack cycle
    logic        mis;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwd;
  } acc_t;

  function automatic acc_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat, input logic mis,
                              input logic [31:0] exp_data, input logic [3:0] exp_be,
                              input logic [31:0] exp_bwd);
    acc_t a;
    a.rd = rd; a.wr = wr; a.size = size; a.uns = uns; a.addr = addr;
    a.wdata = wdata; a.rdata = rdata; a.lat = lat; a.mis = mis;
    a.exp_data = exp_data; a.exp_be = exp_be; a.exp_bwd = exp_bwd;
    return a;
  endfunction

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic rd, input logic wr, input logic [1:0] s,
                                     input logic [31:0] addr);
    return (rd || wr) && ((addr % nbytes(s)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] addr);
    logic [3:0] be = '0;
    int base = (nbytes(s) == 4) ? 0 : int'(addr % 4);
    for (int i = 0; i < nbytes(s); i++) be[base + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic rd, input logic wr, input logic [1:0] s,
                                             input logic uns, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n = nbytes(s);
    logic [31:0] v, mask;
    if (wr || !rd) return 32'd0;
    if (n == 4) return rdata;
    v = rdata >> (8 * (addr % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    mem_read_m = 0; mem_write_m = 0; mem_size_m = 0; mem_unsigned_m = 0;
    alu_result_m = 0; mem_write_data_m = 0;
  endtask

  task automatic scramble_inputs();
    mem_read_m = 1'($urandom); mem_write_m = 1'($urandom);
    mem_size_m = 2'($urandom); mem_unsigned_m = 1'($urandom);
    alu_result_m = $urandom; mem_write_data_m = $urandom;
  endtask

  // Presents one M-stage request in an IDLE cycle and follows it to DONE.
  task automatic run_access(input acc_t a, input bit scramble);
    int exp_req, stall_cnt;
    bit exp_to;
    logic [31:0] want;
    @(posedge clk); #1;
    mem_read_m = a.rd; mem_write_m = a.wr; mem_size_m = a.size;
    mem_unsigned_m = a.uns; alu_result_m = a.addr; mem_write_data_m = a.wdata;
    bus_ack = scramble ? 1'($urandom) : 1'b0;
    bus_rdata = $urandom;
    @(negedge clk);
    check("idle_state", 32'(state), 32'(IDLE));
    check("misalign", 32'(misalign_m), 32'(a.mis));
    check("timeout_idle", 32'(timeout_m), 32'(model_to));
    if (!(a.rd || a.wr) || a.mis) begin
      check("nostall", 32'(stall_m), 32'd0);
      check("noreq", 32'(bus_req), 32'd0);
      check("nodata", mem_read_data_m, 32'd0);
      return;
    end
    stall_cnt = stall_m ? 1 : 0;
    exp_to = (a.lat >= MW);
    exp_req = exp_to ? MW : a.lat + 1;
    exp_q.push_back(exp_to ? 32'd0 : a.exp_data);
    for (int c = 0; c < exp_req; c++) begin
      @(posedge clk); #1;
      if (scramble) scramble_inputs();
      bus_ack = (c == a.lat);
      bus_rdata = (c == a.lat) ? a.rdata : $urandom;
      @(negedge clk);
      if (stall_m) stall_cnt++;
      check("bus_req", 32'(bus_req), 32'd1);
      if (c == 0) begin
        check("bus_addr", bus_addr, a.addr & ~32'd3);
        check("bus_be", 32'(bus_be), 32'(a.exp_be));
        check("bus_wdata", bus_wdata, a.exp_bwd);
        check("bus_we", 32'(bus_we), 32'(a.wr));
      end
    end
    @(posedge clk); #1;
    bus_ack = scramble ? 1'($urandom) : 1'b0;
    bus_rdata = $urandom;
    if (scramble) scramble_inputs();
    @(negedge clk);
    if (exp_to) model_to = 1'b1;
    want = exp_q.pop_front();
    check("done_state", 32'(state), 32'(DONE));
    check("done_noreq", 32'(bus_req), 32'd0);
    check("done_stall", 32'(stall_m), 32'd0);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_req + 1));
    check("read_data", mem_read_data_m, want);
    check("timeout", 32'(timeout_m), 32'(model_to));
    // Next call presents its request in the cycle right after DONE.
    idle_inputs();
  endtask

  // ---------------- test ----------------
  acc_t tbl[13];
  acc_t r;

  initial begin
    idle_inputs();
    bus_ack = 0; bus_rdata = 0;

    tbl[0]  = mk(1, 0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
    tbl[1]  = mk(1, 0, 2'd0, 0, 32'h103, 32'h0,        32'h80123456, 1, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    tbl[2]  = mk(1, 0, 2'd0, 1, 32'h103, 32'h0,        32'h80123456, 0, 0, 32'h00000080, 4'b1000, 32'h0);
    tbl[3]  = mk(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 2, 0, 32'h0,        4'b1100, 32'hABCDABCD);
    tbl[4]  = mk(1, 0, 2'd2, 0, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0);
    tbl[5]  = mk(1, 0, 2'd1, 0, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 32'hFFFF8001, 4'b1100, 32'h0);
    tbl[6]  = mk(1, 0, 2'd1, 1, 32'h100, 32'h0,        32'h1234F00D, 1, 0, 32'h0000F00D, 4'b0011, 32'h0);
    tbl[7]  = mk(0, 1, 2'd0, 0, 32'h301, 32'h000000A5, 32'h0,        0, 0, 32'h0,        4'b0010, 32'hA5A5A5A5);
    tbl[8]  = mk(1, 0, 2'd1, 0, 32'h103, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0);
    tbl[9]  = mk(0, 1, 2'd2, 0, 32'h404, 32'hCAFEF00D, 32'h0,        1, 0, 32'h0,        4'b1111, 32'hCAFEF00D);
    tbl[10] = mk(1, 0, 2'd3, 0, 32'h010, 32'h0,        32'h11223344, 0, 0, 32'h11223344, 4'b1111, 32'h0);
    tbl[11] = mk(1, 1, 2'd2, 0, 32'h020, 32'h55AA55AA, 32'hFFFFFFFF, 0, 0, 32'h0,        4'b1111, 32'h55AA55AA);
    tbl[12] = mk(1, 0, 2'd0, 0, 32'h101, 32'h0,        32'h00007F00, 2, 0, 32'h0000007F, 4'b0010, 32'h0);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_timeout", 32'(timeout_m), 32'd0);
    check("rst_data", mem_read_data_m, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_misalign", 32'(misalign_m), 32'd0);
    rst = 0;

    // directed table
    for (int i = 0; i < 13; i++) run_access(tbl[i], 1'b0);

    // no ack: exactly MW REQ cycles, zero data, sticky timeout
    run_access(mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h12345678, 1000, 0, 32'h0, 4'b1111, 32'h0), 1'b0);
    run_access(tbl[0], 1'b0);

    // randomized against the model
    for (int n = 0; n < 80; n++) begin
      r.rd = 1'($urandom); r.wr = 1'($urandom);
      r.size = 2'($urandom); r.uns = 1'($urandom);
      r.addr = $urandom; r.wdata = $urandom; r.rdata = $urandom;
      if ($urandom_range(0, 3) != 0) r.addr = r.addr - (r.addr % nbytes(r.size));
      r.lat = $urandom_range(0, 5);
      r.mis = model_mis(r.rd, r.wr, r.size, r.addr);
      r.exp_data = model_load(r.rd, r.wr, r.size, r.uns, r.addr, r.rdata);
      r.exp_be = model_be(r.size, r.addr);
      r.exp_bwd = model_wd(r.size, r.wdata);
      run_access(r, 1'b1);
      if ($urandom_range(0, 4) == 0) @(posedge clk);
    end

    // reset in the middle of a request
    @(posedge clk); #1;
    mem_write_m = 1; mem_size_m = 2'd2; alu_result_m = 32'h500; mem_write_data_m = 32'h0BADF00D;
    bus_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req", 32'(bus_req), 32'd1);
    check("mid_timeout", 32'(timeout_m), 32'(model_to));
    #2;
    rst = 1;
    idle_inputs();
    #1;
    check("arst_req", 32'(bus_req), 32'd0);
    check("arst_state", 32'(state), 32'(IDLE));
    check("arst_timeout", 32'(timeout_m), 32'd0);
    check("arst_be", 32'(bus_be), 32'd0);
    model_to = 1'b0;
    @(negedge clk);
    rst = 0;
    run_access(mk(0, 1, 2'd2, 0, 32'h504, 32'h13579BDF, 32'h0, 1, 0, 32'h0, 4'b1111, 32'h13579BDF), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller sitting directly downstream of the pipeline's memory stage. It takes the M-stage load/store request (address from the ALU result, store data, size and signedness), drives a variable-latency request/acknowledge data bus, and returns aligned, sign- or zero-extended load data. It stalls the pipeline until the access completes. It also flags misaligned accesses and bus timeouts.

## Interface
- MAX_WAIT, 255: maximum cycles spent in REQ waiting for bus_ack before the access is aborted (range 1–255).
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_read_m  in  1  M-stage instruction is a load.
- mem_write_m  in  1  M-stage instruction is a store; wins if both are high.
- mem_size_m  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned_m  in  1  zero-extend the load (lbu/lhu); 0 means sign-extend.
- alu_result_m  in  32  byte address.
- mem_write_data_m  in  32  store data, right-justified.
- mem_read_data_m  out  32  extended load result; valid in DONE.
- stall_m  out  1  freeze fetch through M.
- misalign_m  out  1  misaligned access in the current cycle (combinational).
- timeout_m  out  1  sticky bus-timeout flag.
- bus_req  out  1  bus request.
- bus_we  out  1  write enable.
- bus_addr  out  32  word address, with bits [1:0] = 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completion.
- bus_rdata  in  32  read data, sampled on bus_ack.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE**
  - An access is pending when mem_read_m or mem_write_m is high.
  - A pending access is *aligned* when it is a byte access, a half with addr[0]=0, or a word with addr[1:0]=0.
  - Aligned and pending: stall_m=1. Register bus_we, bus_addr, bus_be, bus_wdata, size, unsigned and addr[1:0]. Go to REQ.
  - Misaligned: misalign_m=1, stall_m=0, no bus activity, mem_read_data_m=0. Stay in IDLE.
- **REQ**
  - bus_req=1 and stall_m=1; the registered fields are held stable.
  - The wait counter increments every REQ cycle.
  - On bus_ack=1: capture bus_rdata (loads only) and go to DONE.
  - If the counter reaches MAX_WAIT with no ack: set timeout_m, force the captured data to 0, and go to DONE.
- **DONE**
  - stall_m=0; mem_read_data_m is driven from the captured word, so the pipeline advances at the end of this cycle.
  - Always returns to IDLE next cycle.
- Byte enables:
  - byte: 0001 shifted left by addr[1:0];
  - half: 0011 if addr[1]=0, else 1100;
  - word: 1111.
- Write data:
  - byte: data[7:0] replicated ×4;
  - half: data[15:0] replicated ×2;
  - word: unchanged.
- Load data: select the lane at byte offset addr[1:0], then extend to 32 bits according to mem_unsigned_m.
- bus_ack outside REQ is ignored.
- timeout_m is cleared only by rst.
- Stores return mem_read_data_m=0.

## Timing
- Reset values: every output is 0, state is IDLE, wait counter is 0.
- rst asserted mid-access drops bus_req immediately, with no clock edge required.
- An access with an ack in its first REQ cycle takes 3 cycles: IDLE→REQ→DONE, giving 2 stall cycles.
- Each additional cycle without ack adds one stall cycle.
- Back-to-back accesses: the next instruction is seen in IDLE on the cycle after DONE, so there is no idle bubble beyond that.
- Outputs driven from state: stall_m, misalign_m and mem_read_data_m. Inputs only affect them in IDLE.

## Structure
- Package mem_pkg holds:
  - enum mem_size_t (BYTE, HALF, WORD);
  - enum dmem_state_t (IDLE, REQ, DONE);
  - constant WORD_BYTES=4.
- Sub-module load_extend (combinational): inputs are a 32-bit word, the offset, the size and the unsigned flag; output is the 32-bit result.
- The FSM, wait counter and store lane steering stay in dmem_ctrl.

## Test plan
- **lw with ack latency 0:** addr 0x100, bus_rdata 0xDEADBEEF → bus_be=1111, stall_m high for 2 cycles, DONE shows 0xDEADBEEF.
- **lb and lbu:** addr 0x103, bus_rdata 0x80xxxxxx → lb returns 0xFFFFFF80, lbu returns 0x00000080.
- **sh to 0x202 with data 0x1234ABCD:** bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
- **Misaligned lw at 0x101:** misalign_m=1, stall_m=0, bus_req never asserted.
- **No ack with MAX_WAIT=4:** exactly 4 REQ cycles, then timeout_m=1 (sticky), data 0, pipeline released.
- **rst asserted in REQ:** bus_req falls asynchronously, FSM returns to IDLE, a following sw completes normally.
